// File: rtl/pattern_pkg.sv
// Shared constants for the pattern generator and the pattern detectors it drives:
// symbol encoding, one-hot FSM state encoding and the default BBCBC pattern.
package pattern_pkg;

    localparam logic SYM_B = 1'b0;
    localparam logic SYM_C = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_SEND = 4'b0010,
        S_GAP  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    localparam logic [4:0] PAT_BBCBC     = 5'b00101;
    localparam int         PAT_BBCBC_LEN = 5;

endpackage

// File: rtl/pattern_gen_shreg.sv
// Loadable pattern register with a down-counting symbol index; the current
// symbol is always the MSB of a left-aligned shift copy of the pattern.
module pattern_gen_shreg
    import pattern_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_adv,
    input  logic             i_clr,
    input  logic [PAT_W-1:0] i_pat,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_sym,
    output logic             o_last
);

    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] r_shift;
    logic [LEN_W-1:0] r_lenM1;
    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] w_shamt;
    logic [PAT_W-1:0] w_aligned;

    // Left-align so symbol len-1 lands on the MSB and is sent first.
    assign w_shamt   = LEN_W'(PAT_W) - i_len;
    assign w_aligned = i_pat << w_shamt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat   <= {PAT_W{SYM_B}};
            r_shift <= {PAT_W{SYM_B}};
            r_lenM1 <= '0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_pat   <= w_aligned;
            r_shift <= w_aligned;
            r_lenM1 <= i_len - LEN_W'(1);
            r_idx   <= i_len - LEN_W'(1);
        end else if (i_clr) begin
            r_shift <= {PAT_W{SYM_B}};
            r_idx   <= '0;
        end else if (i_adv) begin
            if (r_idx == '0) begin
                r_shift <= r_pat;
                r_idx   <= r_lenM1;
            end else begin
                r_shift <= {r_shift[PAT_W-2:0], SYM_B};
                r_idx   <= r_idx - LEN_W'(1);
            end
        end
    end

    assign o_sym  = r_shift[PAT_W-1];
    assign o_last = (r_idx == '0);

endmodule

// File: rtl/pattern_gen.sv
// Serial MSB-first pattern transmitter with valid/ready handshake and repeat count.
// Inter-repetition idle gap is compiled in only when PATTERN_GEN_GAP_EN is defined.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [REP_W-1:0] rep_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             ready_i,
    output logic             d_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t           r_state;
    state_t           w_next;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;
    logic [REP_W-1:0] r_rep;
    logic [LEN_W-1:0] w_effLen;
    logic             w_degen;
    logic             w_hs;
    logic             w_last;
    logic             w_final;
    logic             w_load;
    logic             w_clr;
    logic             w_gapNz;
    logic             w_sym;

    assign w_effLen = (len_i > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_i;
    assign w_degen  = (w_effLen == '0) || (rep_i == '0);
    assign w_hs     = r_valid & ready_i;
    assign w_final  = (r_rep == REP_W'(1));
    assign w_clr    = w_hs & w_last & w_final;

    pattern_gen_shreg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_adv  (w_hs),
        .i_clr  (w_clr),
        .i_pat  (pat_i),
        .i_len  (w_effLen),
        .o_sym  (w_sym),
        .o_last (w_last)
    );

`ifdef PATTERN_GEN_GAP_EN
    logic [GAP_W-1:0] r_gapLen;
    logic [GAP_W-1:0] r_gapCnt;
    logic             w_gapStart;
    logic             w_gapDone;

    assign w_gapNz    = (r_gapLen != '0);
    assign w_gapStart = w_hs & w_last & ~w_final & w_gapNz;
    assign w_gapDone  = (r_gapCnt <= GAP_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gapLen <= '0;
            r_gapCnt <= '0;
        end else begin
            if (w_load) begin
                r_gapLen <= gap_i;
            end
            if (w_gapStart) begin
                r_gapCnt <= r_gapLen;
            end else if ((r_state == S_GAP) && (r_gapCnt != '0)) begin
                r_gapCnt <= r_gapCnt - GAP_W'(1);
            end
        end
    end
`else
    logic w_unusedGap;

    assign w_unusedGap = ^gap_i;
    assign w_gapNz     = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (w_degen) begin
                        w_next = S_DONE;
                    end else begin
                        w_load = 1'b1;
                        w_next = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (w_hs && w_last) begin
                    if (w_final) begin
                        w_next = S_DONE;
                    end else if (w_gapNz) begin
                        w_next = S_GAP;
                    end
                end
            end
`ifdef PATTERN_GEN_GAP_EN
            S_GAP: begin
                if (w_gapDone) begin
                    w_next = S_SEND;
                end
            end
`endif
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Flags are decoded from the next state so every output comes straight off a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rep   <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == S_SEND);
            r_busy  <= (w_next == S_SEND) || (w_next == S_GAP);
            r_done  <= (w_next == S_DONE);
            if (w_load) begin
                r_rep <= rep_i;
            end else if (w_hs && w_last) begin
                r_rep <= r_rep - REP_W'(1);
            end
        end
    end

    assign d_o     = w_sym;
    assign valid_o = r_valid;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: hand-computed vector table, reset and
// start-while-busy sequences, and randomized transfers against a slot-list model.
module tb_pattern_gen;
    import pattern_pkg::*;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int REP_W = 4;
    localparam int GAP_W = 3;
`ifdef PATTERN_GEN_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif
    localparam int SLOT_GAP  = 2;
    localparam int SLOT_DONE = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [PAT_W-1:0] pat_i;
    logic [LEN_W-1:0] len_i;
    logic [REP_W-1:0] rep_i;
    logic [GAP_W-1:0] gap_i;
    logic             ready_i;
    logic             d_o;
    logic             valid_o;
    logic             busy_o;
    logic             done_o;

    int nCompared   = 0;
    int nMismatched = 0;
    int expSlots[$];

    typedef struct {
        logic [PAT_W-1:0] pat;
        int               len;
        int               rep;
        int               gap;
        logic [31:0]      stall;
        int               expDone;
        int               expHs;
    } vec_t;

    vec_t vecs[8];

    pattern_gen dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .pat_i   (pat_i),
        .len_i   (len_i),
        .rep_i   (rep_i),
        .gap_i   (gap_i),
        .ready_i (ready_i),
        .d_o     (d_o),
        .valid_o (valid_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Expected per-cycle slots: symbol values 0/1, idle gap cycles, then the done pulse.
    function automatic void buildSlots(input logic [PAT_W-1:0] pat, input int len, input int rep, input int gap);
        int effLen;
        expSlots.delete();
        effLen = (len > PAT_W) ? PAT_W : len;
        if (effLen > 0) begin
            for (int r = 0; r < rep; r++) begin
                if (r > 0 && GAP_ON) begin
                    for (int g = 0; g < gap; g++) expSlots.push_back(SLOT_GAP);
                end
                for (int i = effLen - 1; i >= 0; i--) expSlots.push_back(pat[i] ? 1 : 0);
            end
        end
        expSlots.push_back(SLOT_DONE);
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic applyStimulus(input string name, input logic [PAT_W-1:0] pat, input int len,
                                 input int rep, input int gap, input logic [31:0] stallMask,
                                 input bit randReady, input bit randNoise,
                                 output int doneCycle, output int hsCount);
        int  k;
        int  cyc;
        int  slot;
        logic expValid;
        logic expBusy;
        logic expDone;
        buildSlots(pat, len, rep, gap);
        doneCycle = -1;
        hsCount   = 0;
        start_i = 1'b1;
        pat_i   = pat;
        len_i   = LEN_W'(len);
        rep_i   = REP_W'(rep);
        gap_i   = GAP_W'(gap);
        ready_i = 1'b1;
        @(negedge clk);
        cyc = 1;
        k   = 0;
        while (k < expSlots.size()) begin
            if (cyc > 400) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL %s:timeout: got slot %0d, expected %0d", name, k, expSlots.size());
                break;
            end
            slot     = expSlots[k];
            expValid = (slot < 2);
            expBusy  = (slot != SLOT_DONE);
            expDone  = (slot == SLOT_DONE);
            checkOutput({name, ":valid"}, {31'b0, valid_o}, {31'b0, expValid});
            checkOutput({name, ":busy"},  {31'b0, busy_o},  {31'b0, expBusy});
            checkOutput({name, ":done"},  {31'b0, done_o},  {31'b0, expDone});
            if (expValid) checkOutput({name, ":d"}, {31'b0, d_o}, slot);
            if (expDone && done_o) doneCycle = cyc;
            // Keep hammering start and scrambling inputs to prove they are ignored.
            if (randNoise) begin
                start_i = ($urandom_range(0, 1) == 1);
                pat_i   = PAT_W'($urandom);
                len_i   = LEN_W'($urandom);
                rep_i   = REP_W'($urandom);
                gap_i   = GAP_W'($urandom);
            end else begin
                start_i = 1'b1;
                pat_i   = ~pat;
                len_i   = LEN_W'(3);
                rep_i   = REP_W'(2);
                gap_i   = GAP_W'(1);
            end
            if (randReady) ready_i = ($urandom_range(0, 3) != 0);
            else           ready_i = (cyc < 32) ? !stallMask[cyc] : 1'b1;
            if (valid_o && ready_i) hsCount++;
            if (slot < 2) begin
                if (ready_i) k++;
            end else begin
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        checkOutput({name, ":idleValid"}, {31'b0, valid_o}, 0);
        checkOutput({name, ":idleBusy"},  {31'b0, busy_o},  0);
        checkOutput({name, ":idleDone"},  {31'b0, done_o},  0);
    endtask

    initial begin
        int dc;
        int hs;
        int effLen;
        logic [PAT_W-1:0] rPat;
        int rLen;
        int rRep;
        int rGap;

        vecs[0] = '{8'h05, 5, 1, 0, 32'h0,  6, 5};
        vecs[1] = '{8'h05, 5, 1, 0, 32'hC,  8, 5};
        vecs[2] = '{8'h05, 5, 3, 2, 32'h0,  GAP_ON ? 20 : 16, 15};
        vecs[3] = '{8'h05, 0, 1, 0, 32'h0,  1, 0};
        vecs[4] = '{8'h05, 5, 0, 0, 32'h0,  1, 0};
        vecs[5] = '{8'hA5, 12, 1, 0, 32'h0, 9, 8};
        vecs[6] = '{8'h3C, 8, 2, 0, 32'h50, 19, 16};
        vecs[7] = '{8'h01, 1, 4, 3, 32'h0,  GAP_ON ? 14 : 5, 4};

        rst     = 1'b1;
        start_i = 1'b0;
        pat_i   = '0;
        len_i   = '0;
        rep_i   = '0;
        gap_i   = '0;
        ready_i = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset:d",     {31'b0, d_o},     0);
        checkOutput("reset:valid", {31'b0, valid_o}, 0);
        checkOutput("reset:busy",  {31'b0, busy_o},  0);
        checkOutput("reset:done",  {31'b0, done_o},  0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            applyStimulus($sformatf("vec%0d", v), vecs[v].pat, vecs[v].len, vecs[v].rep, vecs[v].gap,
                          vecs[v].stall, 1'b0, 1'b0, dc, hs);
            checkOutput($sformatf("vec%0d:doneCycle", v), dc, vecs[v].expDone);
            checkOutput($sformatf("vec%0d:handshakes", v), hs, vecs[v].expHs);
        end

        // Asynchronous reset while the third symbol (C) is on the line.
        start_i = 1'b1;
        pat_i   = PAT_W'(PAT_BBCBC);
        len_i   = LEN_W'(PAT_BBCBC_LEN);
        rep_i   = REP_W'(1);
        ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstMid:sym3", {31'b0, d_o}, {31'b0, SYM_C});
        checkOutput("rstMid:sym3Valid", {31'b0, valid_o}, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rstMid:d",     {31'b0, d_o},     0);
        checkOutput("rstMid:valid", {31'b0, valid_o}, 0);
        checkOutput("rstMid:busy",  {31'b0, busy_o},  0);
        checkOutput("rstMid:done",  {31'b0, done_o},  0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rstHold:done",  {31'b0, done_o},  0);
            checkOutput("rstHold:valid", {31'b0, valid_o}, 0);
        end
        rst = 1'b0;
        applyStimulus("afterRst", PAT_W'(PAT_BBCBC), PAT_BBCBC_LEN, 1, 0, 32'h0, 1'b0, 1'b0, dc, hs);
        checkOutput("afterRst:doneCycle", dc, 6);

        // Back-to-back random transfers with random backpressure and input noise.
        for (int t = 0; t < 40; t++) begin
            rPat   = PAT_W'($urandom);
            rLen   = $urandom_range(0, 12);
            rRep   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
            rGap   = $urandom_range(0, 7);
            effLen = (rLen > PAT_W) ? PAT_W : rLen;
            applyStimulus($sformatf("rand%0d", t), rPat, rLen, rRep, rGap, 32'h0, 1'b1, 1'b1, dc, hs);
            checkOutput($sformatf("rand%0d:handshakes", t), hs, effLen * rRep);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
